// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared types and constants for the operand loader
package operand_loader_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam int BTN_A_STEP = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_OP     = 2;
   localparam int BTN_CLR    = 3;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SEQ    = 1'b1;

   // Loaded-flag bit positions
   localparam int FLG_A  = 0;
   localparam int FLG_B  = 1;
   localparam int FLG_OP = 2;

endpackage

// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - board-side switches/buttons in, operand registers and status out
interface operand_loader_if #(
   parameter int NB_DATA    = 8,
   parameter int NB_OPCODE  = 6,
   parameter int NB_BUTTONS = 4
);
   logic [NB_DATA-1:0]    i_switches;
   logic [NB_BUTTONS-1:0] i_botones;
   logic                  i_mode;
   logic [NB_DATA-1:0]    o_reg_dato_A;
   logic [NB_DATA-1:0]    o_reg_dato_B;
   logic [NB_OPCODE-1:0]  o_reg_opcode;
   logic                  o_valid;
   logic                  o_valid_pulse;
   logic                  o_err;
   logic [1:0]            o_state;

   modport master (
      output i_switches, i_botones, i_mode,
      input  o_reg_dato_A, o_reg_dato_B, o_reg_opcode,
      input  o_valid, o_valid_pulse, o_err, o_state
   );

   modport slave (
      input  i_switches, i_botones, i_mode,
      output o_reg_dato_A, o_reg_dato_B, o_reg_opcode,
      output o_valid, o_valid_pulse, o_err, o_state
   );
endinterface

// File: rtl/operand_loader_button_conditioner.sv
// rtl/operand_loader_button_conditioner.sv - 2-FF sync, counter debounce, one-cycle press pulse
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_button,
   output logic o_press
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic             deb_prev_q;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter only survives while the synchronised level keeps disagreeing
   always_comb begin
      cnt_d   = '0;
      deb_d   = deb_q;
      press_d = deb_q & ~deb_prev_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         press_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= i_button;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         press_q    <= press_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_press = press_q;
endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - button decode, sequential-load FSM and ALU operand registers
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int NB_DATA         = 8,
   parameter int NB_OPCODE       = 6,
   parameter int NB_BUTTONS      = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   operand_loader_if.slave  bus
);
   logic [NB_BUTTONS-1:0] press;

   for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_btn
      button_conditioner #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .i_clock  (i_clock),
         .i_reset  (i_reset),
         .i_button (bus.i_botones[g]),
         .o_press  (press[g])
      );
   end

   logic mode_s1_q, mode_s2_q, mode_prev_q;
   logic mode_toggle;

   logic [NB_DATA-1:0]   a_q, a_d, b_q, b_d;
   logic [NB_OPCODE-1:0] op_q, op_d;
   logic [2:0]           flag_q, flag_d;
   state_e               state_q, state_d;
   logic                 valid_q, valid_d;
   logic                 vpulse_q, vpulse_d;
   logic                 err_q, err_d;

   logic       p_a, p_b, p_op, p_clr;
   logic [1:0] n_dir;
   logic       write;
   logic       conflict;

   assign p_a   = press[BTN_A_STEP];
   assign p_b   = press[BTN_B];
   assign p_op  = press[BTN_OP];
   assign p_clr = press[BTN_CLR];
   assign n_dir = {1'b0, p_a} + {1'b0, p_b} + {1'b0, p_op};
   assign mode_toggle = mode_s2_q ^ mode_prev_q;

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      flag_d   = flag_q;
      state_d  = state_q;
      write    = 1'b0;
      conflict = 1'b0;

      if (p_clr) begin
         a_d     = '0;
         b_d     = '0;
         op_d    = '0;
         flag_d  = '0;
         state_d = S_A;
      end else begin
         if (mode_s2_q == MODE_DIRECT) begin
            if (n_dir > 2'd1) begin
               conflict = 1'b1;
            end else if (p_a) begin
               a_d = bus.i_switches;
               flag_d[FLG_A] = 1'b1;
               write = 1'b1;
            end else if (p_b) begin
               b_d = bus.i_switches;
               flag_d[FLG_B] = 1'b1;
               write = 1'b1;
            end else if (p_op) begin
               op_d = bus.i_switches[NB_OPCODE-1:0];
               flag_d[FLG_OP] = 1'b1;
               write = 1'b1;
            end
         end else if (p_a) begin
            if (p_b || p_op) begin
               conflict = 1'b1;
            end else begin
               write = 1'b1;
               case (state_q)
                  S_A: begin
                     a_d = bus.i_switches;
                     flag_d[FLG_A] = 1'b1;
                     state_d = S_B;
                  end
                  S_B: begin
                     b_d = bus.i_switches;
                     flag_d[FLG_B] = 1'b1;
                     state_d = S_OP;
                  end
                  S_OP: begin
                     op_d = bus.i_switches[NB_OPCODE-1:0];
                     flag_d[FLG_OP] = 1'b1;
                     state_d = S_DONE;
                  end
                  default: begin
                     // A fresh set starts: the old B/opcode no longer count as loaded
                     a_d = bus.i_switches;
                     flag_d = 3'b001;
                     state_d = S_B;
                  end
               endcase
            end
         end
         if (mode_toggle) begin
            state_d = S_A;
         end
      end

      valid_d  = &flag_d;
      vpulse_d = write & (&flag_d);
      err_d    = conflict;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         mode_s1_q   <= 1'b0;
         mode_s2_q   <= 1'b0;
         mode_prev_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         flag_q      <= '0;
         state_q     <= S_A;
         valid_q     <= 1'b0;
         vpulse_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mode_s1_q   <= bus.i_mode;
         mode_s2_q   <= mode_s1_q;
         mode_prev_q <= mode_s2_q;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         flag_q      <= flag_d;
         state_q     <= state_d;
         valid_q     <= valid_d;
         vpulse_q    <= vpulse_d;
         err_q       <= err_d;
      end
   end

   assign bus.o_reg_dato_A  = a_q;
   assign bus.o_reg_dato_B  = b_q;
   assign bus.o_reg_opcode  = op_q;
   assign bus.o_valid       = valid_q;
   assign bus.o_valid_pulse = vpulse_q;
   assign bus.o_err         = err_q;
   assign bus.o_state       = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
module tb_operand_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   vp_cnt = 0;
   int   err_cnt = 0;

   operand_loader_if #(.NB_DATA(8), .NB_OPCODE(6), .NB_BUTTONS(4)) bus ();

   operand_loader #(
      .NB_DATA(8), .NB_OPCODE(6), .NB_BUTTONS(4), .DEBOUNCE_CYCLES(4)
   ) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_valid_pulse) vp_cnt <= vp_cnt + 1;
      if (bus.o_err) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] m, input logic [7:0] sw);
      @(negedge clk);
      bus.i_switches = sw;
      bus.i_botones  = m;
      repeat (12) @(negedge clk);
      bus.i_botones = '0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vp0, err0, c0, lat;
      bus.i_switches = '0;
      bus.i_botones  = '0;
      bus.i_mode     = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_A", bus.o_reg_dato_A, 0);
      check("rst_B", bus.o_reg_dato_B, 0);
      check("rst_op", bus.o_reg_opcode, 0);
      check("rst_valid", bus.o_valid, 0);
      check("rst_state", bus.o_state, 0);
      check("rst_err", bus.o_err, 0);

      // Direct mode loads
      vp0 = vp_cnt;
      press(4'b0001, 8'h3C);
      check("dir_A", bus.o_reg_dato_A, 8'h3C);
      check("dir_valid_A", bus.o_valid, 0);
      press(4'b0010, 8'h05);
      check("dir_B", bus.o_reg_dato_B, 8'h05);
      check("dir_vp_none", vp_cnt - vp0, 0);
      press(4'b0100, 8'hE2);
      check("dir_op", bus.o_reg_opcode, 6'h22);
      check("dir_valid", bus.o_valid, 1);
      check("dir_vp_once", vp_cnt - vp0, 1);
      repeat (10) @(negedge clk);
      check("dir_valid_hold", bus.o_valid, 1);

      // Bounce on b1: H L H L H (2 cycles each), then held
      vp0 = vp_cnt;
      bus.i_switches = 8'h5A;
      c0 = 0;
      for (int i = 0; i < 5; i++) begin
         bus.i_botones[1] = ~i[0];
         if (i == 4) c0 = cyc;
         repeat (2) @(negedge clk);
      end
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         if (bus.o_reg_dato_B == 8'h5A) lat = cyc - c0;
         else @(negedge clk);
      end
      check("bounce_latency", lat, 8);
      repeat (10) @(negedge clk);
      bus.i_botones = '0;
      repeat (12) @(negedge clk);
      check("bounce_B", bus.o_reg_dato_B, 8'h5A);
      check("bounce_one_write", vp_cnt - vp0, 1);

      // Conflict b0+b2
      err0 = err_cnt;
      vp0 = vp_cnt;
      press(4'b0101, 8'hFF);
      check("cfl_err", err_cnt - err0, 1);
      check("cfl_A", bus.o_reg_dato_A, 8'h3C);
      check("cfl_op", bus.o_reg_opcode, 6'h22);
      check("cfl_vp", vp_cnt - vp0, 0);

      // Clear with b1
      err0 = err_cnt;
      press(4'b1010, 8'h99);
      check("clr_A", bus.o_reg_dato_A, 0);
      check("clr_B", bus.o_reg_dato_B, 0);
      check("clr_op", bus.o_reg_opcode, 0);
      check("clr_valid", bus.o_valid, 0);
      check("clr_noerr", err_cnt - err0, 0);

      // Sequential mode
      bus.i_mode = 1'b1;
      repeat (6) @(negedge clk);
      check("seq_s0", bus.o_state, 0);
      press(4'b0001, 8'h11);
      check("seq_s1", bus.o_state, 1);
      check("seq_A", bus.o_reg_dato_A, 8'h11);
      press(4'b0010, 8'h77);
      check("seq_b1_ignored", bus.o_reg_dato_B, 0);
      press(4'b0001, 8'h22);
      check("seq_s2", bus.o_state, 2);
      check("seq_B", bus.o_reg_dato_B, 8'h22);
      press(4'b0001, 8'h33);
      check("seq_s3", bus.o_state, 3);
      check("seq_op", bus.o_reg_opcode, 6'h33);
      check("seq_valid", bus.o_valid, 1);
      press(4'b0001, 8'h44);
      check("seq4_A", bus.o_reg_dato_A, 8'h44);
      check("seq4_valid", bus.o_valid, 0);
      check("seq4_state", bus.o_state, 1);

      // Mode change sends FSM to S_A, registers retained
      bus.i_mode = 1'b0;
      repeat (6) @(negedge clk);
      check("mode_state", bus.o_state, 0);
      check("mode_keepA", bus.o_reg_dato_A, 8'h44);

      // Reset during b0 debounce
      bus.i_switches = 8'h77;
      bus.i_botones  = 4'b0001;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bus.i_botones = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      vp0 = vp_cnt;
      repeat (20) @(negedge clk);
      check("rmid_A", bus.o_reg_dato_A, 0);
      check("rmid_B", bus.o_reg_dato_B, 0);
      check("rmid_state", bus.o_state, 0);
      check("rmid_valid", bus.o_valid, 0);
      check("rmid_vp", vp_cnt - vp0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
